// File: rtl/memory_game_pkg.sv
`default_nettype none
//==============================================================================
// Package  : memory_game_pkg
// Summary  : Shared state encoding and score codes for the LED memory game.
// Revision : 1.0 - initial release
//==============================================================================
package memory_game_pkg;

    typedef enum logic [2:0] {
        START        = 3'd0,
        PATTERN_OFF  = 3'd1,
        PATTERN_SHOW = 3'd2,
        WAIT_PLAYER  = 3'd3,
        INCR_SCORE   = 3'd4,
        WINNER       = 3'd5,
        LOSER        = 3'd6
    } state_e;

    localparam logic [3:0] SCORE_WIN  = 4'hA;
    localparam logic [3:0] SCORE_LOSE = 4'hF;

endpackage
`default_nettype wire

// File: rtl/game_step_timer.sv
`default_nettype none
//==============================================================================
// Module   : game_step_timer
// Summary  : Free-running step pulse generator, restartable by i_Clear.
// Revision : 1.0 - initial release
//==============================================================================
module game_step_timer #(
    parameter int CLKS_PER_STEP = 6250000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Step
);

    localparam int               CNT_W   = $clog2(CLKS_PER_STEP);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_STEP - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The pulse is taken from the count alone so the FSM can use it to
    // decide its next state without forming a loop through i_Clear.
    assign o_Step = i_Enable && (count_q == CNT_MAX);

    always_comb begin
        count_d = count_q;
        if (i_Clear || !i_Enable || (count_q == CNT_MAX)) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_game_fsm_param.sv
`default_nettype none
//==============================================================================
// Module   : memory_game_fsm_param
// Summary  : Parametrised LED memory-game controller with inactivity timeout.
// Revision : 1.0 - initial release
//==============================================================================
module memory_game_fsm_param
    import memory_game_pkg::*;
#(
    parameter  int NUM_BUTTONS   = 4,
    parameter  int GAME_LIMIT    = 6,
    parameter  int CLKS_PER_STEP = 6250000,
    parameter  int TIMEOUT_STEPS = 16,
    localparam int ID_W          = $clog2(NUM_BUTTONS)
) (
    input  logic                       i_Clk,
    input  logic                       i_Reset,
    input  logic [NUM_BUTTONS-1:0]     i_Buttons,
    input  logic [GAME_LIMIT*ID_W-1:0] i_Rand_Data,
    output logic [NUM_BUTTONS-1:0]     o_LEDs,
    output logic [3:0]                 o_Score,
    output logic                       o_Game_Over
);

    localparam int              ID_W1      = ID_W + 1;
    localparam logic [ID_W:0]   NB_EXT     = ID_W1'(NUM_BUTTONS);
    localparam int              TO_W       = $clog2(TIMEOUT_STEPS + 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_STEPS - 1);
    localparam logic [3:0]      LAST_SCORE = 4'(GAME_LIMIT - 1);

    state_e                 state_q, state_d;
    logic [3:0]             score_q, score_d;
    logic [3:0]             index_q, index_d;
    logic [TO_W-1:0]        to_q, to_d;
    logic [NUM_BUTTONS-1:0] prev_q;
    logic [NUM_BUTTONS-1:0] rel_q;
    logic [ID_W-1:0]        pattern_q [GAME_LIMIT];

    logic [ID_W-1:0]        w_capture [GAME_LIMIT];
    logic                   w_capture_en;
    logic                   w_step;
    logic                   w_enable;
    logic                   w_clear;
    logic                   w_accept;
    logic                   w_restart;
    logic                   w_multi;
    logic                   w_single;
    logic [3:0]             w_rel_count;
    logic [ID_W-1:0]        w_rel_id;
    logic [ID_W-1:0]        w_expect;

    // Out-of-range random fields fold back into the legal button range.
    for (genvar gi = 0; gi < GAME_LIMIT; gi++) begin : g_capture
        logic [ID_W-1:0] w_field;
        assign w_field       = i_Rand_Data[gi*ID_W +: ID_W];
        assign w_capture[gi] = ({1'b0, w_field} >= NB_EXT) ?
                               ID_W'({1'b0, w_field} - NB_EXT) : w_field;
    end

    always_comb begin
        w_rel_count = '0;
        w_rel_id    = '0;
        for (int k = 0; k < NUM_BUTTONS; k++) begin
            if (rel_q[k]) begin
                w_rel_count = w_rel_count + 4'd1;
                w_rel_id    = ID_W'(k);
            end
        end
        w_expect = '0;
        for (int i = 0; i < GAME_LIMIT; i++) begin
            if (index_q == 4'(i)) begin
                w_expect = pattern_q[i];
            end
        end
    end

    assign w_multi   = (w_rel_count > 4'd1);
    assign w_single  = (w_rel_count == 4'd1);
    assign w_restart = i_Buttons[0] & i_Buttons[1];
    assign w_enable  = (state_q == PATTERN_OFF) || (state_q == PATTERN_SHOW) ||
                       (state_q == WAIT_PLAYER);

    game_step_timer #(
        .CLKS_PER_STEP (CLKS_PER_STEP)
    ) u_step_timer (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Clear  (w_clear),
        .i_Enable (w_enable),
        .o_Step   (w_step)
    );

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        index_d      = index_q;
        to_d         = to_q;
        w_capture_en = 1'b0;
        w_accept     = 1'b0;
        w_clear      = 1'b0;
        if (w_restart) begin
            state_d = START;
        end else begin
            case (state_q)
                START: begin
                    if (!i_Buttons[0] && !i_Buttons[1] && (|rel_q)) begin
                        state_d      = PATTERN_OFF;
                        score_d      = '0;
                        index_d      = '0;
                        w_capture_en = 1'b1;
                    end
                end
                PATTERN_OFF: begin
                    if (w_step) begin
                        state_d = PATTERN_SHOW;
                    end
                end
                PATTERN_SHOW: begin
                    if (w_step) begin
                        if (index_q == score_q) begin
                            index_d = '0;
                            state_d = WAIT_PLAYER;
                        end else begin
                            index_d = index_q + 4'd1;
                            state_d = PATTERN_OFF;
                        end
                    end
                end
                WAIT_PLAYER: begin
                    if (w_multi) begin
                        state_d = LOSER;
                    end else if (w_single && (w_rel_id != w_expect)) begin
                        state_d = LOSER;
                    end else if (w_single) begin
                        w_accept = 1'b1;
                        if (index_q == score_q) begin
                            index_d = '0;
                            state_d = INCR_SCORE;
                        end else begin
                            index_d = index_q + 4'd1;
                        end
                    end else if (w_step) begin
                        if (to_q == TO_LAST) begin
                            state_d = LOSER;
                        end else begin
                            to_d = to_q + TO_W'(1);
                        end
                    end
                end
                INCR_SCORE: begin
                    score_d = score_q + 4'd1;
                    state_d = (score_q == LAST_SCORE) ? WINNER : PATTERN_OFF;
                end
                WINNER, LOSER: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = START;
                end
            endcase
        end
        // Terminal scores are loaded on entry so no transient value is shown.
        if (state_d == WINNER) begin
            score_d = SCORE_WIN;
        end
        if (state_d == LOSER) begin
            score_d = SCORE_LOSE;
        end
        w_clear = (state_d != state_q) || w_accept;
        if (w_clear) begin
            to_d = '0;
        end
    end

    always_comb begin
        o_LEDs = '0;
        case (state_q)
            START, WAIT_PLAYER: o_LEDs = i_Buttons;
            PATTERN_SHOW:       o_LEDs = {{(NUM_BUTTONS-1){1'b0}}, 1'b1} << w_expect;
            WINNER:             o_LEDs = '1;
            default:            o_LEDs = '0;
        endcase
    end

    assign o_Game_Over = (state_q == WINNER) || (state_q == LOSER);
    assign o_Score     = score_q;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= START;
            score_q <= '0;
            index_q <= '0;
            to_q    <= '0;
            prev_q  <= '0;
            rel_q   <= '0;
            for (int i = 0; i < GAME_LIMIT; i++) begin
                pattern_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            index_q <= index_d;
            to_q    <= to_d;
            prev_q  <= i_Buttons;
            rel_q   <= prev_q & ~i_Buttons;
            if (w_capture_en) begin
                for (int i = 0; i < GAME_LIMIT; i++) begin
                    pattern_q[i] <= w_capture[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_game_fsm_param.sv
`default_nettype none
//==============================================================================
// Module   : tb_memory_game_fsm_param
// Summary  : Self-checking bench: reset table, scripted rounds, random games.
// Revision : 1.0 - initial release
//==============================================================================
module tb_memory_game_fsm_param;

    localparam int NB  = 4;
    localparam int GL  = 3;
    localparam int CPS = 4;
    localparam int TS  = 3;
    localparam int IW  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [5:0] rd;
    logic [3:0] led;
    logic [3:0] score;
    logic       go;

    logic       rst3;
    logic [5:0] rd3;
    logic [2:0] led3;
    logic [3:0] score3;
    logic       go3;

    always #5 clk = ~clk;

    memory_game_fsm_param #(
        .NUM_BUTTONS   (NB),
        .GAME_LIMIT    (GL),
        .CLKS_PER_STEP (CPS),
        .TIMEOUT_STEPS (TS)
    ) dut (
        .i_Clk       (clk),
        .i_Reset     (rst),
        .i_Buttons   (btn),
        .i_Rand_Data (rd),
        .o_LEDs      (led),
        .o_Score     (score),
        .o_Game_Over (go)
    );

    memory_game_fsm_param #(
        .NUM_BUTTONS   (3),
        .GAME_LIMIT    (GL),
        .CLKS_PER_STEP (CPS),
        .TIMEOUT_STEPS (TS)
    ) dut3 (
        .i_Clk       (clk),
        .i_Reset     (rst3),
        .i_Buttons   (btn[2:0]),
        .i_Rand_Data (rd3),
        .o_LEDs      (led3),
        .o_Score     (score3),
        .o_Game_Over (go3)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int model_p [GL];

    typedef struct {
        logic       r;
        logic [3:0] b;
        logic [3:0] led;
        logic [3:0] sc;
        logic       go;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int fold(input int v, input int nb);
        return (v >= nb) ? v - nb : v;
    endfunction

    task automatic set_model(input logic [5:0] data);
        for (int i = 0; i < GL; i++) begin
            model_p[i] = fold(int'((data >> (i * IW)) & 6'h3), NB);
        end
    endtask

    // Ends one sample after the edge that leaves START for the first OFF phase.
    task automatic start_game(input logic [5:0] data);
        set_model(data);
        rd  = data;
        btn = 4'b0011;
        tick();
        tick();
        btn = 4'b0000;
        tick();
        tick();
    endtask

    // Round r plays r+1 OFF/SHOW pairs of CPS cycles each, then enters WAIT.
    task automatic playback(input int r);
        int         c_off;
        int         c_on;
        logic [3:0] exp_on;
        for (int j = 0; j <= r; j++) begin
            c_off  = 0;
            c_on   = 0;
            exp_on = 4'b0001 << model_p[j];
            for (int c = 0; c < CPS; c++) begin
                if (led === 4'b0000) c_off++;
                tick();
            end
            for (int c = 0; c < CPS; c++) begin
                if (led === exp_on) c_on++;
                tick();
            end
            check($sformatf("playback_off_r%0d_j%0d", r, j), c_off, CPS);
            check($sformatf("playback_on_r%0d_j%0d", r, j), c_on, CPS);
        end
    endtask

    task automatic press(input int k);
        btn = 4'b0001 << k;
        #1;
        check("wait_led_follow", led, btn);
        tick();
        btn = 4'b0000;
        tick();
        tick();
    endtask

    // mr == GL means the player never errs; otherwise the mistake is at (mr, mp).
    task automatic play_game(input logic [5:0] data, input int mr, input int mp, input int wrong);
        int w;
        start_game(data);
        for (int r = 0; r < GL; r++) begin
            playback(r);
            for (int j = 0; j <= r; j++) begin
                repeat ($urandom_range(0, 4)) tick();
                if (r == mr && j == mp) begin
                    w = (wrong >= 0) ? wrong : (model_p[j] + 1 + int'($urandom_range(0, NB - 2))) % NB;
                    press(w);
                    check("lose_score", score, 4'hF);
                    check("lose_go", go, 1'b1);
                    check("lose_led", led, 4'b0000);
                    return;
                end
                press(model_p[j]);
                if (j < r) check("mid_round_go", go, 1'b0);
            end
            tick();
            if (r < GL - 1) begin
                check($sformatf("round_score_r%0d", r), score, 4'(r + 1));
                check("round_go", go, 1'b0);
            end else begin
                check("win_score", score, 4'hA);
                check("win_go", go, 1'b1);
                check("win_led", led, 4'b1111);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int mr;
        int mp;
        rst  = 1'b0;
        rst3 = 1'b1;
        btn  = 4'b0000;
        rd   = 6'd0;
        rd3  = 6'd0;

        vecs[0] = '{1'b1, 4'b0000, 4'b0000, 4'h0, 1'b0};
        vecs[1] = '{1'b1, 4'b0101, 4'b0101, 4'h0, 1'b0};
        vecs[2] = '{1'b1, 4'b1010, 4'b1010, 4'h0, 1'b0};
        vecs[3] = '{1'b0, 4'b0001, 4'b0001, 4'h0, 1'b0};
        vecs[4] = '{1'b0, 4'b0111, 4'b0111, 4'h0, 1'b0};
        vecs[5] = '{1'b0, 4'b1101, 4'b1101, 4'h0, 1'b0};
        vecs[6] = '{1'b0, 4'b0010, 4'b0010, 4'h0, 1'b0};
        vecs[7] = '{1'b0, 4'b1011, 4'b1011, 4'h0, 1'b0};

        #2;
        for (int i = 0; i < 8; i++) begin
            rst = vecs[i].r;
            btn = vecs[i].b;
            #2;
            check($sformatf("start_led_v%0d", i), led, vecs[i].led);
            check($sformatf("start_score_v%0d", i), score, vecs[i].sc);
            check($sformatf("start_go_v%0d", i), go, vecs[i].go);
            @(posedge clk);
            #3;
        end
        tick();

        play_game(6'b10_01_11, GL, 0, -1);
        play_game(6'b10_01_11, 1, 1, 2);

        start_game(6'b10_01_11);
        playback(0);
        repeat (11) tick();
        check("timeout_early_go", go, 1'b0);
        tick();
        check("timeout_go", go, 1'b1);
        check("timeout_score", score, 4'hF);

        start_game(6'b10_01_11);
        playback(0);
        press(3);
        tick();
        playback(1);
        repeat (6) tick();
        press(3);
        repeat (11) tick();
        check("timer_restart_go", go, 1'b0);
        tick();
        check("timer_restart_lose", go, 1'b1);

        start_game(6'b10_01_11);
        playback(0);
        btn = 4'b1100;
        tick();
        btn = 4'b0000;
        tick();
        check("multi_pre_go", go, 1'b0);
        tick();
        check("multi_go", go, 1'b1);
        check("multi_score", score, 4'hF);

        for (int g = 0; g < 12; g++) begin
            mr = int'($urandom_range(0, GL));
            mp = (mr < GL) ? int'($urandom_range(0, mr)) : 0;
            play_game(6'($urandom), mr, mp, -1);
        end

        rd3  = 6'b00_01_11;
        rst3 = 1'b0;
        start_game(6'b10_01_11);
        repeat (CPS) tick();
        check("nb3_fold_led", led3, 3'b001);
        check("nb4_show_led", led, 4'b1000);
        #3;
        rst  = 1'b1;
        rst3 = 1'b1;
        btn  = 4'b0100;
        #1;
        check("nb3_rst_led", led3, 3'b100);
        check("nb3_rst_score", score3, 4'h0);
        check("nb3_rst_go", go3, 1'b0);
        check("rst_show_led", led, 4'b0100);
        check("rst_show_score", score, 4'h0);
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_game_fsm_param.md
Name: memory_game_fsm_param

Overview:
Parametrised successor of the LED memory-game controller. It plays back a random sequence on NUM_BUTTONS LEDs, then checks the player's button releases against that sequence. New over the previous generation: configurable button count and game length, an external random source, a player-inactivity timeout, and loss on simultaneous presses. It sits between the debounce filters / LFSR and the 7-segment score decoder.

Parameters:
NUM_BUTTONS, 4, number of buttons and LEDs (2..8); localparam ID_W = clog2(NUM_BUTTONS)
GAME_LIMIT, 6, sequence length needed to win (1..9)
CLKS_PER_STEP, 6250000, clocks per LED off/on phase and per timeout step (>=2)
TIMEOUT_STEPS, 16, steps allowed between player presses before loss (>=1)

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  asynchronous, active-high reset
i_Buttons  in  NUM_BUTTONS  debounced buttons, 1 = pressed
i_Rand_Data  in  GAME_LIMIT*ID_W  random pattern source, sampled on START exit
o_LEDs  out  NUM_BUTTONS  LED drive
o_Score  out  4  current score; 4'hA = win, 4'hF = lose
o_Game_Over  out  1  high in WINNER or LOSER

Behaviour:
- Reset (async): state START, o_Score 0, index 0, pattern regs 0, edge regs 0, timer cleared, o_Game_Over 0.
- Release event: button k goes from 1 to 0 between consecutive samples (registered previous value). Event flags are registered, so a press is seen by the FSM 1 cycle after release.
- Restart: i_Buttons[0] & i_Buttons[1] forces START from any state, synchronously. Takes priority over everything except reset.
- START: o_LEDs = i_Buttons. Exit when buttons 0 and 1 are released and any release event occurs. On exit: o_Score<=0, index<=0, capture pattern, go to PATTERN_OFF.
- Pattern capture: entry i = i_Rand_Data[i*ID_W +: ID_W]. If the value is >= NUM_BUTTONS, store value - NUM_BUTTONS.
- Step timer: clears on every state change and every accepted press. o_Step pulses for 1 cycle once CLKS_PER_STEP cycles have elapsed since the clear, then every CLKS_PER_STEP cycles.
- PATTERN_OFF: o_LEDs all 0. On o_Step go to PATTERN_SHOW.
- PATTERN_SHOW: o_LEDs one-hot at pattern[index]. On o_Step:
  - if index == o_Score: index<=0, go to WAIT_PLAYER
  - else: index++, go to PATTERN_OFF
- WAIT_PLAYER: o_LEDs = i_Buttons. Transitions, in priority order:
  - 2 or more release events in the same cycle -> LOSER
  - single release with id != pattern[index] -> LOSER
  - match with index == o_Score -> index<=0, go to INCR_SCORE
  - match otherwise -> index++, restart timer
  - TIMEOUT_STEPS o_Step pulses with no release -> LOSER
- INCR_SCORE (1 cycle): o_Score++. If o_Score == GAME_LIMIT-1, go to WINNER, else go to PATTERN_OFF.
- WINNER: o_Score<=4'hA, o_Game_Over=1, LEDs all on. LOSER: o_Score<=4'hF, o_Game_Over=1, LEDs all 0. Both hold until the restart combo or reset.
- Reset asserted mid-sequence: outputs return to reset values at once; no pulse leaks through from the timer.
- Illegal state encoding -> START.

Decomposition:
- Package memory_game_pkg: state enum (START, PATTERN_OFF, PATTERN_SHOW, WAIT_PLAYER, INCR_SCORE, WINNER, LOSER; 3 bits), SCORE_WIN=4'hA, SCORE_LOSE=4'hF.
- Sub-module game_step_timer (i_Clk, i_Reset, i_Clear, i_Enable, o_Step). Parametrised by CLKS_PER_STEP. Enabled in PATTERN_OFF, PATTERN_SHOW and WAIT_PLAYER.

Test Plan:
Bench params: NUM_BUTTONS=4, GAME_LIMIT=3, CLKS_PER_STEP=4, TIMEOUT_STEPS=3.
1. Assert i_Reset mid-clock; toggle buttons -> o_Score=0, o_Game_Over=0, o_LEDs follow i_Buttons.
2. i_Rand_Data=6'b10_01_11; hold buttons 0+1, release, answer each round correctly -> LED rounds show {3}, {3,1}, {3,1,2}, each SHOW 4 cycles; o_Score 1, 2, then 4'hA with o_Game_Over=1.
3. Same pattern; in round 2 press 3 then 2 -> o_Score=4'hF.
4. Enter WAIT_PLAYER and press nothing -> LOSER exactly 12 cycles after entry. Press within 11 cycles -> timer restarts, no loss.
5. Release buttons 2 and 3 in the same cycle in WAIT_PLAYER -> LOSER next cycle.
6. NUM_BUTTONS=3, field value 3 -> LED0 shown. Async reset during PATTERN_SHOW -> o_LEDs=i_Buttons and state START within the same cycle.
